rv32_csr_trap_unit: RTL

//  Parametrised machine-mode CSR file with trap unit for the RV32 core. Adds real cycle/instret counters,

---
 rtl/rv32_csr_pkg.sv | 55 +++++
 rtl/rv32_irq_sync.sv | 24 ++
 rtl/rv32_csr_trap_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap unit.
// CSR addresses, op encodings, cause codes and mstatus bit positions.
package rv32_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINH = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  localparam int MST_MIE  = 3;
  localparam int MST_MPIE = 7;

  localparam logic [1:0] TVEC_DIRECT = 2'b00;
  localparam logic [1:0] TVEC_VECTOR = 2'b01;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // Fixed priority among pending-and-enabled lines: MEI > MSI > MTI.
  function automatic logic [4:0] irq_winner(input logic [31:0] p);
    if (p[11])     return IRQ_MEI;
    else if (p[3]) return IRQ_MSI;
    else if (p[7]) return IRQ_MTI;
    else           return 5'd0;
  endfunction

endpackage

// File: rtl/rv32_irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt level.
// Output is the last flop of a STAGES-deep shift chain.
module rv32_irq_sync
  import rv32_csr_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_in,
  output logic irq_sync
);

  logic [STAGES-1:0] ff;

  // Shift the raw level through the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], irq_in};
  end

  assign irq_sync = ff[STAGES-1];

endmodule

// File: rtl/rv32_csr_trap_unit.sv
// Machine-mode CSR file, counters, interrupt arbitration and trap
// entry/exit bookkeeping for the RV32 execute stage.
module rv32_csr_trap_unit
  import rv32_csr_pkg::*;
#(
  parameter int          COUNTER_W   = 64,
  parameter int          VECTORED_EN = 1,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_valid,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_op,
  input  logic [31:0] csr_wdata,
  input  logic        csr_src_zero,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_inc,
  input  logic        exc_trigger,
  input  logic        exc_is_irq,
  input  logic [30:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_trigger,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic        irq_ext,
  output logic        irq_req,
  output logic [4:0]  irq_cause,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out
);

  localparam int HW = COUNTER_W - 32;

  logic st_mie, st_mpie;
  logic [31:0] mie_q, mscratch_q, mepc_q;
  logic [31:0] mcause_q, mtval_q;
  logic [29:0] tvec_base;
  logic [1:0]  tvec_mode;
  logic [1:0]  inh_q;
  logic [COUNTER_W-1:0] mcycle_q, minstret_q;
  logic [COUNTER_W-1:0] cyc_inc, ins_inc;
  logic [31:0] cyc_hi, ins_hi;
  logic ext_s, soft_s, tmr_s;
  logic [31:0] mip, pend, mstatus, nv;
  logic [31:0] tvec_addr;
  logic addr_ok, op_rw, op_set, op_clr;
  logic wr_type, we;
  logic we_mstatus, we_mie, we_mtvec, we_minh;
  logic we_mscratch, we_mepc, we_mcause, we_mtval;
  logic we_cyc_lo, we_cyc_hi, we_ins_lo, we_ins_hi;

  rv32_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_ext), .irq_sync(ext_s)
  );
  rv32_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_soft (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_soft), .irq_sync(soft_s)
  );
  rv32_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tmr (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_timer), .irq_sync(tmr_s)
  );

  assign mip = {20'b0, ext_s, 3'b0, tmr_s, 3'b0, soft_s, 3'b0};
  assign pend = mip & mie_q;
  assign mstatus = {19'b0, 2'b11, 3'b0, st_mpie,
                    3'b0, st_mie, 3'b0};
  assign cyc_hi = 32'(mcycle_q >> 32);
  assign ins_hi = 32'(minstret_q >> 32);

  // Read mux and address legality.
  always_comb begin
    csr_rdata = '0;
    addr_ok   = 1'b1;
    unique case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus;
      CSR_MISA:      csr_rdata = MISA_VAL;
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = {tvec_base, tvec_mode};
      CSR_MCOUNTINH: csr_rdata = {29'b0, inh_q[1], 1'b0, inh_q[0]};
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP:       csr_rdata = mip;
      CSR_MCYCLE,
      CSR_CYCLE:     csr_rdata = mcycle_q[31:0];
      CSR_MINSTRET,
      CSR_INSTRET:   csr_rdata = minstret_q[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:    csr_rdata = cyc_hi;
      CSR_MINSTRETH,
      CSR_INSTRETH:  csr_rdata = ins_hi;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:    csr_rdata = '0;
      CSR_MHARTID:   csr_rdata = HART_ID;
      default:       addr_ok   = 1'b0;
    endcase
  end

  // Op decode and read-modify-write value.
  always_comb begin
    op_rw  = 1'b0;
    op_set = 1'b0;
    op_clr = 1'b0;
    unique case (csr_op)
      OP_RW, OP_RWI: op_rw  = 1'b1;
      OP_RS, OP_RSI: op_set = 1'b1;
      OP_RC, OP_RCI: op_clr = 1'b1;
      default: ;
    endcase
    nv = csr_wdata;
    if (op_set) nv = csr_rdata | csr_wdata;
    if (op_clr) nv = csr_rdata & ~csr_wdata;
  end

  assign wr_type = op_rw | ((op_set | op_clr) & ~csr_src_zero);
  assign csr_illegal = csr_valid &
    (~addr_ok | ~(op_rw | op_set | op_clr) |
     (wr_type & (&csr_addr[11:10])));
  assign we = csr_valid & ~csr_illegal & wr_type;

  assign we_mstatus  = we & (csr_addr == CSR_MSTATUS);
  assign we_mie      = we & (csr_addr == CSR_MIE);
  assign we_mtvec    = we & (csr_addr == CSR_MTVEC);
  assign we_minh     = we & (csr_addr == CSR_MCOUNTINH);
  assign we_mscratch = we & (csr_addr == CSR_MSCRATCH);
  assign we_mepc     = we & (csr_addr == CSR_MEPC);
  assign we_mcause   = we & (csr_addr == CSR_MCAUSE);
  assign we_mtval    = we & (csr_addr == CSR_MTVAL);
  assign we_cyc_lo   = we & (csr_addr == CSR_MCYCLE);
  assign we_cyc_hi   = we & (csr_addr == CSR_MCYCLEH);
  assign we_ins_lo   = we & (csr_addr == CSR_MINSTRET);
  assign we_ins_hi   = we & (csr_addr == CSR_MINSTRETH);

  // Trap state: a trap overrides MRET and CSR writes to these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (exc_trigger) begin
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
      mepc_q   <= exc_pc & ~32'h3;
      mcause_q <= {exc_is_irq,
                   exc_is_irq ? {26'b0, irq_cause} : exc_cause};
      mtval_q  <= exc_tval;
    end else begin
      if (mret_trigger) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (we_mstatus) begin
        st_mie  <= nv[MST_MIE];
        st_mpie <= nv[MST_MPIE];
      end
      if (we_mepc)   mepc_q   <= nv & ~32'h3;
      if (we_mcause) mcause_q <= nv;
      if (we_mtval)  mtval_q  <= nv;
    end
  end

  // Plain WARL registers untouched by traps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= '0;
      tvec_base  <= '0;
      tvec_mode  <= TVEC_DIRECT;
      inh_q      <= '0;
      mscratch_q <= '0;
    end else begin
      if (we_mie) mie_q <= nv & MIE_MASK;
      if (we_mtvec) begin
        tvec_base <= nv[31:2];
        tvec_mode <= (VECTORED_EN != 0 && nv[1:0] == TVEC_VECTOR)
                   ? TVEC_VECTOR : TVEC_DIRECT;
      end
      if (we_minh)     inh_q      <= {nv[2], nv[0]};
      if (we_mscratch) mscratch_q <= nv;
    end
  end

  assign cyc_inc = mcycle_q +
    {{(COUNTER_W-1){1'b0}}, ~inh_q[0]};
  assign ins_inc = minstret_q +
    {{(COUNTER_W-1){1'b0}}, instret_inc & ~inh_q[1]};

  // Counters: a written half takes the CSR value, the other half counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (we_cyc_lo)
        mcycle_q <= {cyc_inc[COUNTER_W-1:32], nv};
      else if (we_cyc_hi)
        mcycle_q <= {nv[HW-1:0], cyc_inc[31:0]};
      else
        mcycle_q <= cyc_inc;
      if (we_ins_lo)
        minstret_q <= {ins_inc[COUNTER_W-1:32], nv};
      else if (we_ins_hi)
        minstret_q <= {nv[HW-1:0], ins_inc[31:0]};
      else
        minstret_q <= ins_inc;
    end
  end

  // Registered interrupt request and winning cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      irq_req   <= st_mie & (|pend);
      irq_cause <= irq_winner(pend);
    end
  end

  assign tvec_addr = {tvec_base, 2'b00};
  assign trap_vector =
    (tvec_mode == TVEC_VECTOR && exc_is_irq)
      ? tvec_addr + {25'b0, irq_cause, 2'b00}
      : tvec_addr;
  assign mepc_out = mepc_q;

endmodule
